// File: rtl/stable_matching_pkg.sv
// Shared definitions for the sequential stable-matching engine: sizing helper,
// FSM state encoding and bit-offset helpers for the packed preference vector.
package stable_matching_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PROPOSE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    // ceil(log2(v)), never below 1 so single-entry fields keep one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Bit offset of proposer s, rank k.
    function automatic int p_off(input int s, input int k, input int ks, input int log_r);
        return (s * ks + k) * log_r;
    endfunction

    // Bit offset of reviewer r, rank k; base is where the reviewer section starts.
    function automatic int r_off(input int r, input int k, input int kr, input int log_s,
                                 input int base);
        return base + (r * kr + k) * log_s;
    endfunction

endpackage

// File: rtl/stable_matching_rank.sv
// Combinational search of one reviewer list: reports whether a proposer index
// appears and the rank of its first (most preferred) occurrence.
module stable_matching_rank
    import stable_matching_pkg::*;
#(
    parameter  int Kr     = 4,
    parameter  int LOG_S  = 2,
    localparam int RANK_W = clog2_min1(Kr)
) (
    input  logic [Kr*LOG_S-1:0] list,
    input  logic [LOG_S-1:0]    idx,
    output logic                found,
    output logic [RANK_W-1:0]   rank
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
        found = 1'b0;
        rank  = '0;
        for (int k = 0; k < Kr; k++) begin
            if (!found && list[k*LOG_S +: LOG_S] == idx) begin
                found = 1'b1;
                rank  = RANK_W'(k);
            end
        end
    end

endmodule

// File: rtl/stable_matching_seq.sv
// Sequential Gale-Shapley engine: one proposal per PROPOSE cycle, lowest-index
// free proposer first, reviewers keep the best-ranked suitor seen so far.
module stable_matching_seq
    import stable_matching_pkg::*;
#(
    parameter  int S      = 4,
    parameter  int Ks     = S,
    parameter  int R      = S,
    parameter  int Kr     = Ks,
    localparam int LOG_S  = clog2_min1(S),
    localparam int LOG_R  = clog2_min1(R),
    localparam int P_BASE = S * Ks * LOG_R,
    localparam int P_W    = R * Kr * LOG_S + P_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [P_W-1:0]     p_input,
    output logic               busy,
    output logic               done,
    output logic [R*LOG_S-1:0] o,
    output logic [R-1:0]       o_valid
);

    localparam int RANK_W = clog2_min1(Kr);
    localparam int PTR_W  = clog2_min1(Ks + 1);
    localparam int CNT_W  = clog2_min1(S * Ks + 1);

    state_t              state, state_nxt;
    logic [P_W-1:0]      pref_reg;
    logic [PTR_W-1:0]    ptr          [S];
    logic [S-1:0]        p_matched;
    logic [LOG_S-1:0]    o_arr        [R];
    logic [RANK_W-1:0]   partner_rank [R];
    logic [CNT_W-1:0]    prop_cnt;

    logic                load_run, do_propose;
    logic                sel_found;
    logic [LOG_S-1:0]    sel;
    logic [PTR_W-1:0]    ptr_sel;
    logic [LOG_R-1:0]    tgt, tgt_idx;
    logic                tgt_ok;
    logic [Kr*LOG_S-1:0] rev_list;
    logic                found;
    logic [RANK_W-1:0]   rank;
    logic                accept;

    assign busy = (state == LOAD) || (state == PROPOSE);
    assign done = (state == FINISH);

    for (genvar r = 0; r < R; r++) begin : g_out
        assign o[r*LOG_S +: LOG_S] = o_arr[r];
    end

    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        for (int s = 0; s < S; s++) begin
            if (!sel_found && !p_matched[s] && int'(ptr[s]) < Ks) begin
                sel_found = 1'b1;
                sel       = LOG_S'(s);
            end
        end
        ptr_sel  = sel_found ? ptr[sel] : '0;
        tgt      = pref_reg[p_off(int'(sel), int'(ptr_sel), Ks, LOG_R) +: LOG_R];
        tgt_ok   = int'(tgt) < R;
        tgt_idx  = tgt_ok ? tgt : '0;
        rev_list = pref_reg[r_off(int'(tgt_idx), 0, Kr, LOG_S, P_BASE) +: Kr*LOG_S];
    end

    stable_matching_rank #(
        .Kr    (Kr),
        .LOG_S (LOG_S)
    ) u_rank (
        .list  (rev_list),
        .idx   (sel),
        .found (found),
        .rank  (rank)
    );

    // Out-of-range targets and absent proposers are plain rejections.
    assign accept = tgt_ok && found &&
                    (!o_valid[tgt_idx] || rank < partner_rank[tgt_idx]);

    always_comb begin
        state_nxt  = state;
        load_run   = 1'b0;
        do_propose = 1'b0;
        unique case (state)
            IDLE, FINISH: begin
                if (start) begin
                    state_nxt = LOAD;
                    load_run  = 1'b1;
                end
            end
            LOAD: state_nxt = PROPOSE;
            PROPOSE: begin
                if (!sel_found || int'(prop_cnt) >= S * Ks) state_nxt = FINISH;
                else                                      do_propose = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the preference store has no reset; it is only read after a load overwrites it.
    always_ff @(posedge clk) begin
        if (load_run) pref_reg <= p_input;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            p_matched <= '0;
            o_valid   <= '0;
            prop_cnt  <= '0;
            for (int s = 0; s < S; s++) ptr[s] <= '0;
            for (int r = 0; r < R; r++) begin
                o_arr[r]        <= '0;
                partner_rank[r] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (load_run) begin
                p_matched <= '0;
                o_valid   <= '0;
                prop_cnt  <= '0;
                for (int s = 0; s < S; s++) ptr[s] <= '0;
                for (int r = 0; r < R; r++) begin
                    o_arr[r]        <= '0;
                    partner_rank[r] <= '0;
                end
            end else if (do_propose) begin
                ptr[sel] <= ptr[sel] + PTR_W'(1);
                prop_cnt <= prop_cnt + CNT_W'(1);
                if (accept) begin
                    // The displaced partner is never sel, which is currently unmatched.
                    if (o_valid[tgt_idx]) p_matched[o_arr[tgt_idx]] <= 1'b0;
                    p_matched[sel]        <= 1'b1;
                    o_arr[tgt_idx]        <= sel;
                    o_valid[tgt_idx]      <= 1'b1;
                    partner_rank[tgt_idx] <= rank;
                end
            end
        end
    end

endmodule

// File: tb/tb_stable_matching_seq.sv
// Directed bench for stable_matching_seq: a 4x4 instance for the full-list cases
// and a 4x2 instance for incomplete lists.
module tb_stable_matching_seq;

    // Per-list packing: entry k at bits [2k+:2]. [0,1,2,3] -> E4, [3,2,1,0] -> 1B.
    localparam logic [63:0] ID_IN   = {{4{8'hE4}}, {4{8'hE4}}};
    localparam logic [63:0] DISP_IN = {{4{8'h1B}}, {4{8'hE4}}};
    // Ks=2: proposers [0,1] -> 4; reviewers r0 [0,1] -> 4, r1 [2,3] -> E, r2/r3 [0,0].
    localparam logic [31:0] INC_IN  = {16'h00E4, 16'h4444};

    logic        clk = 1'b0;
    logic        rst, start, start2;
    logic [63:0] p_input;
    logic [31:0] p_input2;
    logic        busy, done, busy2, done2;
    logic [7:0]  o, o2;
    logic [3:0]  o_valid, o_valid2;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    stable_matching_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .p_input (p_input),
        .busy    (busy),
        .done    (done),
        .o       (o),
        .o_valid (o_valid)
    );

    stable_matching_seq #(.Ks(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .p_input (p_input2),
        .busy    (busy2),
        .done    (done2),
        .o       (o2),
        .o_valid (o_valid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [63:0] pin);
        p_input = pin;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        start2   = 1'b1;
        p_input  = ID_IN;
        p_input2 = INC_IN;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (o !== 8'h00) begin bad++; $display("FAIL reset_o: got %h want 00", o); end
        total++; if (o_valid !== 4'h0) begin bad++; $display("FAIL reset_o_valid: got %b want 0000", o_valid); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy2: got %b want 0", busy2); end
        rst    = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_identity();
        int n;
        launch(ID_IN);
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL id_load: got busy=%b done=%b want 1 0", busy, done); end
        wait_done(n);
        total++; if (n !== 12) begin bad++; $display("FAIL id_latency: got %0d want 12", n); end
        total++; if (o !== 8'hE4) begin bad++; $display("FAIL id_o: got %h want e4", o); end
        total++; if (o_valid !== 4'hF) begin bad++; $display("FAIL id_o_valid: got %b want 1111", o_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL id_busy_end: got %b want 0", busy); end
        repeat (3) tick();
        total++; if (done !== 1'b1 || o !== 8'hE4 || o_valid !== 4'hF) begin
            bad++; $display("FAIL id_hold: got done=%b o=%h ov=%b want 1 e4 1111", done, o, o_valid);
        end
    endtask

    task automatic test_displacement();
        int n;
        launch(DISP_IN);
        wait_done(n);
        total++; if (n !== 12) begin bad++; $display("FAIL disp_latency: got %0d want 12", n); end
        total++; if (o !== 8'h1B) begin bad++; $display("FAIL disp_o: got %h want 1b", o); end
        total++; if (o_valid !== 4'hF) begin bad++; $display("FAIL disp_o_valid: got %b want 1111", o_valid); end
    endtask

    task automatic test_incomplete();
        int n;
        p_input2 = INC_IN;
        start2   = 1'b1;
        tick();
        start2   = 1'b0;
        n = 0;
        while (!done2 && n < 200) begin
            tick();
            n++;
        end
        total++; if (n !== 9) begin bad++; $display("FAIL inc_latency: got %0d want 9", n); end
        total++; if (o2 !== 8'h08) begin bad++; $display("FAIL inc_o: got %h want 08", o2); end
        total++; if (o_valid2 !== 4'b0011) begin bad++; $display("FAIL inc_o_valid: got %b want 0011", o_valid2); end
    endtask

    task automatic test_busy_start();
        int n;
        launch(DISP_IN);
        repeat (3) tick();
        p_input = ID_IN;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_start_busy: got %b want 1", busy); end
        wait_done(n);
        total++; if (n + 4 !== 12) begin bad++; $display("FAIL busy_start_latency: got %0d want 12", n + 4); end
        total++; if (o !== 8'h1B || o_valid !== 4'hF) begin
            bad++; $display("FAIL busy_start_o: got o=%h ov=%b want 1b 1111", o, o_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        launch(ID_IN);
        repeat (4) tick();
        // Three proposals done: s0->r0 accepted, s1->r0 rejected, s1->r1 accepted.
        total++; if (o_valid !== 4'b0011 || o !== 8'h04) begin
            bad++; $display("FAIL mid_partial: got o=%h ov=%b want 04 0011", o, o_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got busy=%b done=%b want 0 0", busy, done); end
        total++; if (o !== 8'h00 || o_valid !== 4'h0) begin bad++; $display("FAIL mid_rst_o: got o=%h ov=%b want 00 0000", o, o_valid); end
        launch(ID_IN);
        wait_done(n);
        total++; if (n !== 12) begin bad++; $display("FAIL mid_rerun_latency: got %0d want 12", n); end
        total++; if (o !== 8'hE4 || o_valid !== 4'hF) begin
            bad++; $display("FAIL mid_rerun_o: got o=%h ov=%b want e4 1111", o, o_valid);
        end
    endtask

    task automatic test_restart();
        int n;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_pre_done: got %b want 1", done); end
        launch(DISP_IN);
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL restart_drop: got done=%b busy=%b want 0 1", done, busy); end
        total++; if (o_valid !== 4'h0 || o !== 8'h00) begin bad++; $display("FAIL restart_clear: got o=%h ov=%b want 00 0000", o, o_valid); end
        wait_done(n);
        total++; if (n !== 12) begin bad++; $display("FAIL restart_latency: got %0d want 12", n); end
        total++; if (o !== 8'h1B || o_valid !== 4'hF) begin
            bad++; $display("FAIL restart_o: got o=%h ov=%b want 1b 1111", o, o_valid);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        start2   = 1'b0;
        p_input  = '0;
        p_input2 = '0;
        test_reset();
        test_identity();
        test_displacement();
        test_incomplete();
        test_busy_start();
        test_reset_mid_run();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stable_matching_seq.md
STABLE_MATCHING_SEQ -- requirements
Module: stable_matching_seq

Interface
REQ-001 Parameter S, default 4: number of proposers (list A).
REQ-002 Parameter Ks, default S: preference-list length per proposer.
REQ-003 Parameter R, default S: number of reviewers (list B).
REQ-004 Parameter Kr, default Ks: preference-list length per reviewer.
REQ-005 Local logS = ceil(log2 S) and logR = ceil(log2 R), each at least 1.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to load p_input and run.
REQ-009 p_input  input  R*Kr*logS + S*Ks*logR  packed preferences.
  - Proposer s, rank k, is at bits [(s*Ks+k)*logR +: logR].
  - Reviewer r, rank k, is at bits [S*Ks*logR + (r*Kr+k)*logS +: logS].
  - Rank 0 is most preferred.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until the next accepted start or rst.
REQ-012 o  output  R*logS  partner of reviewer r at bits [r*logS +: logS].
REQ-013 o_valid  output  R  bit r high when reviewer r is matched.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, PROPOSE, FINISH.
REQ-015 In IDLE or FINISH, start=1 SHALL register p_input, clear all matches and proposal pointers, clear done, and enter LOAD.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 LOAD SHALL last exactly one cycle and SHALL set busy=1 on entry; the FSM then enters PROPOSE.
REQ-018 Each PROPOSE cycle SHALL perform exactly one proposal, as follows.
  - Proposer selection: the lowest-index proposer that is unmatched and whose next-pointer is below Ks.
  - Target: r = that proposer's preference at its next-pointer; the next-pointer then increments by 1.
  - Acceptance: reviewer r accepts only if s appears in r's list, and r is either unmatched or ranks s strictly better than its current partner.
  - On acceptance: o[r] := s, o_valid[r] := 1, s becomes matched, and any displaced partner becomes unmatched.
  - On rejection: no match state changes.
REQ-019 A proposer preference value of R or greater SHALL be treated as a rejection.
REQ-020 A reviewer list SHALL be searched from rank 0 upward, and the first occurrence of s defines its rank.
REQ-021 When no proposer is eligible at the start of a PROPOSE cycle, the FSM SHALL enter FINISH without proposing.
REQ-022 A proposal counter SHALL force entry to FINISH after S*Ks proposals, as a safety bound.
REQ-023 In FINISH: busy=0 and done=1; o and o_valid SHALL hold their values until the next accepted start or rst.
REQ-024 Total latency from start to done SHALL be 2 + P cycles, where P is the number of proposals made.
REQ-025 o and o_valid SHALL change only in PROPOSE cycles or on run start; o[r] SHALL be 0 whenever o_valid[r]=0.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, o=0, o_valid=0, clear all counters and pointers, and discard a run in progress.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 Package stable_matching_pkg SHALL hold the log2 function, the FSM state enum and the bit-offset helper functions.
REQ-029 Sub-module stable_matching_rank SHALL be instantiated once. It is a combinational reviewer-list search with:
  - inputs: one reviewer list and a proposer index;
  - outputs: found and a rank of width ceil(log2 Kr).

Verification
REQ-030 Identity case: S=4, Ks=4; every proposer list [0,1,2,3]; every reviewer list [0,1,2,3] -> 10 proposals, done at cycle 12 after start, o_valid=4'b1111, o = r0:0, r1:1, r2:2, r3:3.
REQ-031 Displacement case: same proposer lists; every reviewer list [3,2,1,0] -> 10 proposals, o = r0:3, r1:2, r2:1, r3:0, o_valid=4'b1111.
REQ-032 Incomplete lists: S=4, Ks=2; every proposer list [0,1]; reviewer r0 list [0,1]; r1 list [2,3] -> 7 proposals, o_valid=4'b0011, o[r0]=0, o[r1]=2.
REQ-033 Busy start: assert start during PROPOSE of the REQ-031 run -> run is unaffected; final o is identical to REQ-031.
REQ-034 Reset mid-run: assert rst in the 4th PROPOSE cycle -> next cycle busy=0, done=0, o=0, o_valid=0; a subsequent start reproduces the REQ-030 result exactly.
REQ-035 Restart after completion: start while done=1 -> done drops on the next cycle and the new run completes normally.
